jtpang_objdma: RTL and testbench
================================

Name: jtpang_objdma

Overview:
- Object-table DMA engine, directly upstream of the object renderer.
- On a CPU-triggered `dma_go` it requests the Z80 bus and waits for `busak_n`.
- It then reads the object table out of VRAM through the shared `dma_addr` / `dma_din` path and writes each byte into the renderer's object buffer.
- It releases the bus when the last byte is written.

Parameters:
- AW, 9, width of `dma_addr` and `buf_addr`.
- DMA_LEN, 384, number of bytes copied per transfer (1..2^AW).

Ports:
- clk  in  1  system clock (48 MHz).
- rst  in  1  synchronous reset, active high.
- cen  in  1  transfer clock enable (pxl_cen); all state advances only on cen=1 except reset.
- dma_go  in  1  single-clk pulse from CPU write decode; starts a transfer.
- busrq  out  1  bus request to Z80, active high.
- busak_n  in  1  Z80 bus acknowledge, active low.
- dma_addr  out  AW  VRAM read address.
- dma_din  in  8  VRAM read data, valid one cen after `dma_addr`.
- buf_we  out  1  object buffer write strobe (one clk, coincident with cen).
- buf_addr  out  AW  object buffer write address.
- buf_din  out  8  object buffer write data.
- busy  out  1  high from accepted `dma_go` until bus released.
- LVBL  in  1  vertical blank, active low; used only with the optional feature.
- buf_bank  out  1  renderer read bank; used only with the optional feature.

Behaviour:
- Reset values: busrq=0, busy=0, buf_we=0, dma_addr=0, buf_addr=0, buf_din=0, buf_bank=0, FSM=IDLE, pending=0.
- `dma_go` is sampled on every clk, not gated by cen. It sets `pending`, which is cleared when the FSM leaves IDLE.
- IDLE: if pending, on the next cen go to REQ. In the same cen set busrq=1, busy=1, dma_addr=0.
- REQ: hold busrq. On the first cen with busak_n=0, go to COPY. No timeout.
- COPY, on each cen with busak_n=0:
  - dma_addr increments.
  - The data read at the previous address is written: buf_addr = dma_addr−1, buf_din = dma_din, buf_we=1.
  - The first cen in COPY issues no write (pipeline fill).
  - The cen writing byte DMA_LEN−1 moves to DONE.
- COPY with busak_n=1 on a cen: pause. No write, no address advance; the pipeline stage is re-primed on resume, so the byte is re-read, not lost.
- Address wrap: dma_addr stops at DMA_LEN and never wraps within a transfer.
- DONE: busrq=0 on the next cen, busy=0 in that same cen, then return to IDLE.
- Transfer timing: DMA_LEN+1 cens from entering COPY to DONE, with no pauses.
- `dma_go` while busy: latched in pending. A second transfer starts after IDLE is re-entered; multiple pulses collapse into one.
- Reset mid-transfer: next clk busrq=0, buf_we=0, FSM=IDLE. A partial buffer is left as is.
- Widths: all address arithmetic is AW-bit unsigned; DMA_LEN is compared against an AW+1-bit counter.

Optional Feature:
- Macro: JTPANG_OBJDMA_DBUF_EN.
- With the macro:
  - The object buffer is double-banked. Writes target bank `~buf_bank`.
  - A completed transfer sets `swap_pend`.
  - On the falling edge of LVBL (sampled on cen), `buf_bank` toggles if `swap_pend`, which then clears.
  - A reset or aborted transfer never sets `swap_pend`.
- Without the macro:
  - `buf_bank` is constant 0 and LVBL is ignored.
  - Writes go straight to the single bank the renderer reads.

Decomposition:
- Shared package jtpang_pkg: FSM state encoding (IDLE, REQ, COPY, DONE) and default constants OBJ_DMA_LEN=384 and OBJ_AW=9, for reuse by jtpang_obj.
- No sub-module: counter, pipeline register and FSM fit in one module.
- LVBL edge detection is inline under the macro.

Test Plan:
- Basic transfer, with VRAM model data = addr[7:0] ^ 8'h5A, busak_n dropping 3 cens after busrq:
  - exactly 384 buf_we pulses, addresses 0..383 with matching data;
  - busrq low 1 cen after the last write; busy falls with it.
- Bus pause, busak_n=1 for 5 cens mid-COPY at address 100: no writes during the pause; byte 99 rewritten correctly after resume; total writes = 384 distinct addresses, all correct.
- Retrigger, dma_go pulsed twice during a transfer: exactly one further transfer follows; busrq toggles low for ≥1 cen between transfers.
- Reset mid-transfer, rst at byte 200: the next clk shows busrq=0, busy=0, buf_we=0; a fresh dma_go restarts from address 0.
- Delayed grant, busak_n held high 1000 cens: FSM stays in REQ with busrq=1 and no writes; it proceeds normally once busak_n=0.
- Bank swap, with JTPANG_OBJDMA_DBUF_EN: complete a transfer mid-frame; buf_bank stays 0 until LVBL falls, then reads 1; a second frame without DMA keeps buf_bank=1.

Source files
------------

// File: rtl/jtpang_pkg.sv
// Shared definitions for the jtpang object path (object DMA and object renderer).
package jtpang_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_COPY = 2'd2,
    ST_DONE = 2'd3
  } objdma_st_t;

  localparam int OBJ_DMA_LEN = 384;
  localparam int OBJ_AW      = 9;

endpackage

// File: rtl/jtpang_objdma_if.sv
// Bus-side bundle of the object DMA: Z80 bus request/grant, VRAM read path and object buffer write path.
interface jtpang_objdma_if
  import jtpang_pkg::*;
#(
  parameter int AW = OBJ_AW
);

  logic          busrq;
  logic          busak_n;
  logic [AW-1:0] dma_addr;
  logic [7:0]    dma_din;
  logic          buf_we;
  logic [AW-1:0] buf_addr;
  logic [7:0]    buf_din;

  modport master (
    output busrq, dma_addr, buf_we, buf_addr, buf_din,
    input  busak_n, dma_din
  );

  modport slave (
    input  busrq, dma_addr, buf_we, buf_addr, buf_din,
    output busak_n, dma_din
  );

endinterface

// File: rtl/jtpang_objdma.sv
// Object-table DMA: on dma_go grabs the Z80 bus and copies DMA_LEN bytes VRAM -> object buffer, one byte per granted cen.
// DMA_LEN+1 granted cens in COPY; busak_n high on a cen pauses and re-primes. Double-banked buffer under JTPANG_OBJDMA_DBUF_EN.
module jtpang_objdma
  import jtpang_pkg::*;
#(
  parameter int AW      = OBJ_AW,
  parameter int DMA_LEN = OBJ_DMA_LEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cen,
  input  logic            dma_go,
  output logic            busy,
  input  logic            LVBL,
  output logic            buf_bank,
  jtpang_objdma_if.master bus
);

  localparam logic [AW:0]   LEN  = (AW+1)'(DMA_LEN);
  localparam logic [AW:0]   ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] AONE = AW'(1);

  objdma_st_t    r_st;
  logic          r_pending;
  logic          r_busrq;
  logic          r_busy;
  logic          r_fill;
  logic [AW:0]   r_cnt;
  logic          r_we;
  logic [AW-1:0] r_baddr;
  logic [7:0]    r_bdin;

  logic          w_leave_idle;
  logic          w_last;
  logic [AW-1:0] w_wr_addr;

  assign w_leave_idle = cen & (r_st == ST_IDLE) & r_pending;
  // r_fill means dma_din holds the byte at r_cnt-1, so this cen may write it
  assign w_last       = r_fill & (r_cnt == LEN);
  assign w_wr_addr    = r_cnt[AW-1:0] - AONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st      <= ST_IDLE;
      r_pending <= 1'b0;
      r_busrq   <= 1'b0;
      r_busy    <= 1'b0;
      r_fill    <= 1'b0;
      r_cnt     <= '0;
      r_we      <= 1'b0;
      r_baddr   <= '0;
      r_bdin    <= '0;
    end else begin
      r_pending <= dma_go | (r_pending & ~w_leave_idle);
      r_we      <= 1'b0;
      if (cen) begin
        case (r_st)
          ST_IDLE: begin
            if (r_pending) begin
              r_st    <= ST_REQ;
              r_busrq <= 1'b1;
              r_busy  <= 1'b1;
              r_cnt   <= '0;
              r_fill  <= 1'b0;
            end
          end
          ST_REQ: begin
            if (!bus.busak_n) r_st <= ST_COPY;
          end
          ST_COPY: begin
            if (!bus.busak_n) begin
              if (r_cnt != LEN) r_cnt <= r_cnt + ONE;
              r_fill <= 1'b1;
              if (r_fill) begin
                r_we    <= 1'b1;
                r_baddr <= w_wr_addr;
                r_bdin  <= bus.dma_din;
              end
              if (w_last) r_st <= ST_DONE;
            end else if (r_fill) begin
              // step back so the unwritten byte is fetched again once the bus returns
              r_cnt  <= r_cnt - ONE;
              r_fill <= 1'b0;
            end
          end
          ST_DONE: begin
            r_busrq <= 1'b0;
            r_busy  <= 1'b0;
            r_st    <= ST_IDLE;
          end
          default: r_st <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.busrq    = r_busrq;
  assign bus.dma_addr = r_cnt[AW-1:0];
  assign bus.buf_we   = r_we;
  assign bus.buf_addr = r_baddr;
  assign bus.buf_din  = r_bdin;
  assign busy         = r_busy;

`ifdef JTPANG_OBJDMA_DBUF_EN
  // DMA fills bank ~buf_bank; the renderer flips to it at the next frame start after a full copy
  logic r_lvbl_l;
  logic r_swap_pend;
  logic r_bank;
  logic w_vb_fall;
  logic w_done;

  assign w_vb_fall = r_lvbl_l & ~LVBL;
  assign w_done    = (r_st == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lvbl_l    <= 1'b0;
      r_swap_pend <= 1'b0;
      r_bank      <= 1'b0;
    end else if (cen) begin
      r_lvbl_l    <= LVBL;
      r_swap_pend <= w_done | (r_swap_pend & ~w_vb_fall);
      if (w_vb_fall && r_swap_pend) r_bank <= ~r_bank;
    end
  end

  assign buf_bank = r_bank;
`else
  logic w_unused_lvbl;
  assign w_unused_lvbl = LVBL;
  assign buf_bank      = 1'b0;
`endif

endmodule

// File: tb/tb_jtpang_objdma.sv
// Bench for jtpang_objdma: VRAM and Z80 grant models, scoreboard of buffer writes, directed scenarios.
module tb_jtpang_objdma;

  localparam int AW  = 9;
  localparam int LEN = 384;
`ifdef JTPANG_OBJDMA_DBUF_EN
  localparam logic DBUF = 1'b1;
`else
  localparam logic DBUF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, cen, dma_go, busy, LVBL, buf_bank;

  jtpang_objdma_if #(.AW(AW)) bus ();

  jtpang_objdma #(.AW(AW), .DMA_LEN(LEN)) dut (
    .clk      (clk),
    .rst      (rst),
    .cen      (cen),
    .dma_go   (dma_go),
    .busy     (busy),
    .LVBL     (LVBL),
    .buf_bank (buf_bank),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] vram(input logic [AW-1:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  // VRAM: data for the address presented at one cen appears at the next cen
  always @(posedge clk) if (cen) bus.dma_din <= vram(bus.dma_addr);

  // cen generator and Z80 grant model
  int grant_delay = 3;
  int pause_at    = -1;
  int pause_left  = 0;
  int rq_cnt      = 0;
  int granted_cens = 0;
  int pause_hits  = 0;
  bit paused      = 1'b0;

  initial begin
    cen = 1'b0;
    bus.busak_n = 1'b1;
    forever begin
      @(negedge clk);
      cen = ~cen;
      if (cen) begin
        if (!bus.busrq) begin
          rq_cnt = 0; bus.busak_n = 1'b1; paused = 1'b0; granted_cens = 0;
        end else begin
          if (pause_left > 0) begin
            pause_left--; bus.busak_n = 1'b1;
          end else if (pause_at >= 0 && !paused && !bus.busak_n && int'(bus.dma_addr) == pause_at) begin
            paused = 1'b1; pause_hits++; pause_left = 4; bus.busak_n = 1'b1;
          end else begin
            bus.busak_n = !(rq_cnt >= grant_delay);
          end
          rq_cnt++;
          if (!bus.busak_n) granted_cens++;
        end
      end
    end
  end

  // scoreboard / model
  bit   written [0:511];
  int   cen_idx = 0, rises = 0, xfers = 0;
  int   cur_nwr = 0, next_exp = 0, last_we_cen = 0, rise_cen = 0, first_we_cen = 0;
  int   cur_first_addr = 0, cur_last_addr = -1;
  logic [7:0] cur_first_dat = 0, cur_last_dat = 0;
  int   s_nwr = 0, s_first_addr = 0, s_last_addr = 0, s_granted = 0, s_wait = 0;
  logic [7:0] s_first_dat = 0, s_last_dat = 0;
  bit   prev_rq = 0, pause_seen = 0, fell, ordered;
  logic exp_bank = 1'b0;
  bit   swap_pend = 0, lv_prev = 0;
  int   distinct;

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        prev_rq = 0; exp_bank = 1'b0; swap_pend = 0; lv_prev = 0; cur_nwr = 0;
        continue;
      end
      chk("busy_vs_busrq", 32'(busy), 32'(bus.busrq));
      if (cen) begin
        cen_idx++;
        fell = prev_rq && !bus.busrq;
        if (DBUF) begin
          if (lv_prev && !LVBL && swap_pend) exp_bank = ~exp_bank;
          if (lv_prev && !LVBL) swap_pend = 0;
          if (fell) swap_pend = 1;
        end
        lv_prev = LVBL;
        if (!prev_rq && bus.busrq) begin
          rises++;
          for (int i = 0; i < 512; i++) written[i] = 0;
          cur_nwr = 0; next_exp = 0; pause_seen = 0; rise_cen = cen_idx; cur_last_addr = -1;
        end
        if (bus.busrq && bus.busak_n && cur_nwr > 0) pause_seen = 1;
        if (bus.buf_we) begin
          chk("we_granted", 32'(bus.busak_n), 32'd0);
          chk("we_in_range", 32'(int'(bus.buf_addr) < LEN), 32'd1);
          chk("we_data", 32'(bus.buf_din), 32'(vram(bus.buf_addr)));
          ordered = (int'(bus.buf_addr) == next_exp) ||
                    (pause_seen && int'(bus.buf_addr) + 1 == next_exp);
          chk("we_order", 32'(ordered), 32'd1);
          if (int'(bus.buf_addr) == next_exp) next_exp++;
          pause_seen = 0;
          if (cur_nwr == 0) begin
            cur_first_addr = int'(bus.buf_addr); cur_first_dat = bus.buf_din; first_we_cen = cen_idx;
          end
          written[bus.buf_addr] = 1;
          cur_nwr++;
          cur_last_addr = int'(bus.buf_addr); cur_last_dat = bus.buf_din; last_we_cen = cen_idx;
        end
        if (fell) begin
          xfers++;
          distinct = 0;
          for (int i = 0; i < 512; i++) distinct += int'(written[i]);
          chk("distinct_addrs", 32'(distinct), 32'(LEN));
          chk("busrq_low_after_last_we", 32'(cen_idx - last_we_cen), 32'd1);
          s_nwr = cur_nwr; s_first_addr = cur_first_addr; s_first_dat = cur_first_dat;
          s_last_addr = cur_last_addr; s_last_dat = cur_last_dat;
          s_granted = granted_cens; s_wait = first_we_cen - rise_cen;
        end
      end else begin
        chk("we_off_cen", 32'(bus.buf_we), 32'd0);
      end
      chk("buf_bank", 32'(buf_bank), 32'(exp_bank));
      prev_rq = bus.busrq;
    end
  end

  task automatic go();
    @(negedge clk); dma_go = 1'b1;
    @(negedge clk); dma_go = 1'b0;
  endtask

  task automatic wait_xfers(input int target, input int budget, input string name);
    int n = 0;
    while (xfers < target && n < budget) begin @(posedge clk); n++; end
    chk(name, 32'(xfers >= target), 32'd1);
  endtask

  task automatic wait_wr_addr(input int a, input int budget, input string name);
    int n = 0;
    while (cur_last_addr != a && n < budget) begin @(posedge clk); n++; end
    chk(name, 32'(cur_last_addr == a), 32'd1);
  endtask

  int base_x, base_r;

  initial begin
    rst = 1'b1; dma_go = 1'b0; LVBL = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_busrq", 32'(bus.busrq), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_buf_we", 32'(bus.buf_we), 32'd0);
    chk("rst_dma_addr", 32'(bus.dma_addr), 32'd0);
    chk("rst_buf_addr", 32'(bus.buf_addr), 32'd0);
    chk("rst_buf_din", 32'(bus.buf_din), 32'd0);
    chk("rst_buf_bank", 32'(buf_bank), 32'd0);
    @(negedge clk); rst = 1'b0;

    // basic transfer
    go();
    wait_xfers(1, 3000, "basic_done");
    chk("basic_nwr", 32'(s_nwr), 32'd384);
    chk("basic_first_addr", 32'(s_first_addr), 32'd0);
    chk("basic_first_dat", 32'(s_first_dat), 32'h5A);
    chk("basic_last_addr", 32'(s_last_addr), 32'd383);
    chk("basic_last_dat", 32'(s_last_dat), 32'h25);
    // grant cen in REQ + DMA_LEN+1 COPY cens + DONE cen
    chk("basic_granted_cens", 32'(s_granted), 32'd387);

    // bus pause mid-copy
    pause_at = 100;
    go();
    wait_xfers(2, 3000, "pause_done");
    chk("pause_hit", 32'(pause_hits), 32'd1);
    chk("pause_nwr_ge", 32'(s_nwr >= 384), 32'd1);
    pause_at = -1;

    // retrigger during a transfer
    base_x = xfers; base_r = rises;
    go();
    wait_wr_addr(50, 2000, "retrig_progress");
    go();
    repeat (10) @(posedge clk);
    go();
    wait_xfers(base_x + 2, 5000, "retrig_done");
    repeat (100) @(posedge clk);
    #1;
    chk("retrig_rises", 32'(rises - base_r), 32'd2);
    chk("retrig_xfers", 32'(xfers - base_x), 32'd2);
    chk("retrig_idle_busrq", 32'(bus.busrq), 32'd0);

    // delayed grant
    grant_delay = 1000;
    base_x = xfers;
    go();
    repeat (1800) @(posedge clk);
    #1;
    chk("dly_busrq", 32'(bus.busrq), 32'd1);
    chk("dly_busy", 32'(busy), 32'd1);
    chk("dly_no_writes", 32'(cur_nwr), 32'd0);
    wait_xfers(base_x + 1, 4000, "dly_done");
    chk("dly_wait_ge1000", 32'(s_wait >= 1000), 32'd1);
    grant_delay = 3;

    // reset mid-transfer
    base_x = xfers;
    go();
    wait_wr_addr(200, 2000, "rst_progress");
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_busrq", 32'(bus.busrq), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_buf_we", 32'(bus.buf_we), 32'd0);
    chk("midrst_dma_addr", 32'(bus.dma_addr), 32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("midrst_no_xfer", 32'(xfers), 32'(base_x));
    go();
    wait_xfers(base_x + 1, 3000, "midrst_restart_done");
    chk("midrst_restart_first", 32'(s_first_addr), 32'd0);

    // bank swap on the frame start following a complete transfer
    go();
    wait_xfers(base_x + 2, 3000, "bank_xfer_done");
    repeat (4) @(posedge clk);
    #1;
    chk("bank_midframe", 32'(buf_bank), 32'd0);
    @(negedge clk); LVBL = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("bank_after_vb", 32'(buf_bank), 32'(DBUF));
    @(negedge clk); LVBL = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk); LVBL = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("bank_second_frame", 32'(buf_bank), 32'(DBUF));
    @(negedge clk); LVBL = 1'b1;
    repeat (4) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
